inst_sram_responder: RTL

//  Responder end of the instruction-SRAM port driven by the fetch stage: a synchronous

---
 rtl/inst_sram_responder_pkg.sv | 22 ++
 rtl/inst_sram_fill_ctrl.sv | 70 +++++++
 rtl/inst_sram_responder.sv | 103 ++++++++++
 3 files changed

// File: rtl/inst_sram_responder_pkg.sv
// Shared constants and types for the instruction-SRAM responder and its fill engine.
package inst_sram_responder_pkg;

  localparam logic [31:0] RESET_VECTOR  = 32'h1C00_0000;
  localparam logic [31:0] NOP_WORD      = 32'h0340_0000;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BE_W          = WORD_W / 8;
  localparam int unsigned DEFAULT_DEPTH = 1024;
  localparam int unsigned DEFAULT_IDX_W = $clog2(DEFAULT_DEPTH);

  // Fill FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Payload of the single array write port
  typedef struct packed {
    logic [BE_W-1:0]   be;
    logic [WORD_W-1:0] data;
  } sram_wr_t;

endpackage

// File: rtl/inst_sram_fill_ctrl.sv
// Fill engine: walks every word index once, then pulses done for one cycle.
module inst_sram_fill_ctrl
  import inst_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             fill_start,
  output logic             fill_we_c,
  output logic [IDX_W-1:0] fill_idx_c,
  output logic             fill_busy,
  output logic             fill_done
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;
  logic             busy_d;
  logic             done_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fill_busy <= busy_d;
      fill_done <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      ST_FILL: begin
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    fill_we_c  = (state_q == ST_FILL);
    fill_idx_c = cnt_q;
  end

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction-SRAM responder: synchronous word RAM with read-first byte writes,
// held response data, out-of-range flagging and a whole-array pattern fill.
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter logic [31:0] BASE_ADDR = RESET_VECTOR,
  parameter logic [31:0] OOR_DATA  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        fill_start,
  input  logic [31:0] fill_pattern,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        err_oor,
  output logic        err_busy_req
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];

  logic [31:0]      off_c;
  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;
  logic             req_c;
  logic             fill_we_c;
  logic [IDX_W-1:0] fill_idx_c;
  logic             wr_en_c;
  logic [IDX_W-1:0] wr_idx_c;
  sram_wr_t         wr_c;

  inst_sram_fill_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_fill_ctrl (
    .clk        (clk),
    .resetn     (resetn),
    .fill_start (fill_start),
    .fill_we_c  (fill_we_c),
    .fill_idx_c (fill_idx_c),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done)
  );

  // Address decode; the subtraction wraps so addresses below the base fall out of range
  always_comb begin
    off_c      = inst_sram_addr - BASE_ADDR;
    in_range_c = ((off_c >> (IDX_W + 2)) == 32'd0);
    idx_c      = off_c[IDX_W+1:2];
    req_c      = inst_sram_en && !fill_busy;
  end

  // Fill owns the write port whenever it runs; port requests are dropped while busy
  always_comb begin
    wr_en_c  = req_c && in_range_c && (inst_sram_wen != 4'b0000);
    wr_idx_c = idx_c;
    wr_c.be  = inst_sram_wen;
    wr_c.data = inst_sram_wdata;
    if (fill_we_c) begin
      wr_en_c   = 1'b1;
      wr_idx_c  = fill_idx_c;
      wr_c.be   = {BE_W{1'b1}};
      wr_c.data = fill_pattern;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (wr_c.be[b]) begin
          mem[wr_idx_c][8*b +: 8] <= wr_c.data[8*b +: 8];
        end
      end
    end
  end

  // Response register reads the pre-write word and holds when no request is accepted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_sram_rdata <= 32'h0000_0000;
      err_oor         <= 1'b0;
      err_busy_req    <= 1'b0;
    end else begin
      if (req_c) begin
        inst_sram_rdata <= in_range_c ? mem[idx_c] : OOR_DATA;
        if (!in_range_c) begin
          err_oor <= 1'b1;
        end
      end
      if (inst_sram_en && fill_busy) begin
        err_busy_req <= 1'b1;
      end
    end
  end

endmodule
